// File: rtl/fpu_pkg.sv
// Shared fpu types: command encoding, requester FSM states and
// IEEE field sizes derived from the operand width.
package fpu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'h0,
        SUB = 4'h1,
        MUL = 4'h2,
        DIV = 4'h3
    } fpu_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        ACK,
        DRAIN
    } req_state_t;

    localparam int CMD_W = 4;
    localparam int SEQ_W = 8;

    function automatic int exp_size(input int bitness);
        if (bitness == 64) return 11;
        if (bitness == 16) return 5;
        return 8;
    endfunction

    function automatic int mant_size(input int bitness);
        return bitness - exp_size(bitness) - 1;
    endfunction

endpackage

// File: rtl/fpu_job_fifo.sv
// Synchronous job FIFO; wrap bit in the pointers separates full from empty.
// A pop frees a slot for a push in the same cycle even when full.
module fpu_job_fifo #(
    parameter int WIDTH = 76,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fpu_requester.sv
// Buffers fpu jobs and issues them one at a time, returning each
// result (or a watchdog timeout) in order through a registered slot.
module fpu_requester
    import fpu_pkg::*;
#(
    parameter int bitness = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [bitness-1:0] job_a,
    input  logic [bitness-1:0] job_b,
    input  fpu_cmd_t           job_cmd,
    output logic               fpu_input_rdy,
    input  logic               fpu_input_ack,
    input  logic               fpu_output_rdy,
    output logic               fpu_output_ack,
    output logic [bitness-1:0] fpu_data_a,
    output logic [bitness-1:0] fpu_data_b,
    output fpu_cmd_t           fpu_command,
    input  logic [bitness-1:0] fpu_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [bitness-1:0] res_data,
    output logic [SEQ_W-1:0]   res_seq,
    output logic               res_timeout,
    output logic               err_sticky
);

    localparam int JW   = 2*bitness + CMD_W + SEQ_W;
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    req_state_t         state;
    req_state_t         state_n;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [JW-1:0]      wdata;
    logic [JW-1:0]      rdata;
    logic [SEQ_W-1:0]   push_seq;
    logic [SEQ_W-1:0]   cur_seq;
    logic [WD_W-1:0]    wd_cnt;
    logic               drained;
    logic               accept;
    logic               load_res;
    logic               load_to;
    logic               ack_set;
    logic [bitness-1:0] head_a;
    logic [bitness-1:0] head_b;
    fpu_cmd_t           head_cmd;
    logic [SEQ_W-1:0]   head_seq;

    assign job_ready = !full;
    assign push      = job_valid && job_ready;
    assign wdata     = {job_a, job_b, job_cmd, push_seq};

    assign head_a   = rdata[JW-1 -: bitness];
    assign head_b   = rdata[JW-1-bitness -: bitness];
    assign head_cmd = fpu_cmd_t'(rdata[SEQ_W +: CMD_W]);
    assign head_seq = rdata[SEQ_W-1:0];

    fpu_job_fifo #(
        .WIDTH (JW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Issue is withheld while the slot is occupied, so a result never overwrites one.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        accept   = 1'b0;
        load_res = 1'b0;
        load_to  = 1'b0;
        ack_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !res_valid) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (fpu_input_ack) begin
                    accept  = 1'b1;
                    state_n = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (fpu_output_rdy) begin
                    load_res = 1'b1;
                    ack_set  = 1'b1;
                    state_n  = ACK;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    load_to = 1'b1;
                    state_n = DRAIN;
                end
            end
            ACK: begin
                if (!fpu_output_rdy) state_n = IDLE;
            end
            DRAIN: begin
                if (!drained && fpu_output_rdy) ack_set = 1'b1;
                else if (drained && !fpu_output_rdy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            push_seq       <= '0;
            cur_seq        <= '0;
            wd_cnt         <= '0;
            drained        <= 1'b0;
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
            fpu_data_a     <= '0;
            fpu_data_b     <= '0;
            fpu_command    <= ADD;
            res_valid      <= 1'b0;
            res_data       <= '0;
            res_seq        <= '0;
            res_timeout    <= 1'b0;
            err_sticky     <= 1'b0;
        end else begin
            fpu_output_ack <= ack_set;
            if (push) push_seq <= push_seq + 1'b1;
            if (pop) begin
                fpu_data_a    <= head_a;
                fpu_data_b    <= head_b;
                fpu_command   <= head_cmd;
                cur_seq       <= head_seq;
                fpu_input_rdy <= 1'b1;
            end
            if (accept) begin
                fpu_input_rdy <= 1'b0;
                wd_cnt        <= '0;
            end else if (state == WAIT_RES) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // Late response after a timeout is acked once and thrown away.
            if (load_to) drained <= 1'b0;
            else if (ack_set && state == DRAIN) drained <= 1'b1;
            if (res_valid && res_ready) res_valid <= 1'b0;
            if (load_res || load_to) begin
                res_valid   <= 1'b1;
                res_data    <= load_res ? fpu_result : '0;
                res_seq     <= cur_seq;
                res_timeout <= load_to;
            end
            if (load_to) err_sticky <= 1'b1;
        end
    end

endmodule
